// File: rtl/clock_time_counter.sv
// Time-of-day counter: packed-BCD hh:mm:ss driven by a 1 Hz tick, with a RUN/SET_HH/SET_MM edit FSM.
// Optional macro TWELVE_HOUR_EN maps the 24-hour register to a 12-hour display with a pm flag.
module clock_time_counter #(
  parameter logic [7:0] INIT_HH = 8'h00,
  parameter logic [7:0] INIT_MM = 8'h00,
  parameter logic [7:0] INIT_SS = 8'h00
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       _1s,
  input  logic       mode,
  input  logic       inc,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       set_hh,
  output logic       set_mm,
  output logic       day_tick,
  output logic       pm
);

  typedef enum logic [1:0] {RUN, SET_HH, SET_MM} state_t;

  state_t     state, state_nxt;
  logic [7:0] hh_r, mm_r, ss_r;
  logic [7:0] hh_nxt, mm_nxt, ss_nxt;
  logic       day_nxt;

  // Two-digit BCD increment that wraps to 00 after reaching top.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top)
      return '0;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    state_nxt = state;
    hh_nxt    = hh_r;
    mm_nxt    = mm_r;
    ss_nxt    = ss_r;
    day_nxt   = 1'b0;
    case (state)
      RUN: begin
        if (_1s) begin
          ss_nxt = bcd_inc(ss_r, 8'h59);
          if (ss_r == 8'h59) begin
            mm_nxt = bcd_inc(mm_r, 8'h59);
            if (mm_r == 8'h59) begin
              hh_nxt  = bcd_inc(hh_r, 8'h23);
              day_nxt = (hh_r == 8'h23);
            end
          end
        end
        if (mode)
          state_nxt = SET_HH;
      end
      SET_HH: begin
        if (mode)
          state_nxt = SET_MM;
        else if (inc)
          hh_nxt = bcd_inc(hh_r, 8'h23);
      end
      SET_MM: begin
        if (mode) begin
          state_nxt = RUN;
          ss_nxt    = '0;
        end else if (inc) begin
          mm_nxt = bcd_inc(mm_r, 8'h59);
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= RUN;
      hh_r     <= INIT_HH;
      mm_r     <= INIT_MM;
      ss_r     <= INIT_SS;
      set_hh   <= 1'b0;
      set_mm   <= 1'b0;
      day_tick <= 1'b0;
    end else begin
      state    <= state_nxt;
      hh_r     <= hh_nxt;
      mm_r     <= mm_nxt;
      ss_r     <= ss_nxt;
      set_hh   <= (state_nxt == SET_HH);
      set_mm   <= (state_nxt == SET_MM);
      day_tick <= day_nxt;
    end
  end

  assign mm = mm_r;
  assign ss = ss_r;

`ifdef TWELVE_HOUR_EN
  // Display-only mapping; the hour register and its wrap stay 24-hour.
  always_comb begin
    hh = hh_r;
    pm = 1'b0;
    case (hh_r)
      8'h00: hh = 8'h12;
      8'h12: pm = 1'b1;
      8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19: begin
        hh = {4'd0, hh_r[3:0] - 4'd2};
        pm = 1'b1;
      end
      8'h20: begin hh = 8'h08; pm = 1'b1; end
      8'h21: begin hh = 8'h09; pm = 1'b1; end
      8'h22: begin hh = 8'h10; pm = 1'b1; end
      8'h23: begin hh = 8'h11; pm = 1'b1; end
      default: ;
    endcase
  end
`else
  assign hh = hh_r;
  assign pm = 1'b0;
`endif

endmodule

// File: tb/tb_clock_time_counter.sv
// Bench for clock_time_counter: two instances (default and 23:59:58 init) checked against a seconds-of-day model.
module tb_clock_time_counter;

  logic clk = 1'b0;
  logic clr = 1'b0, tick_1s = 1'b0, mode = 1'b0, inc = 1'b0;
  logic [7:0] a_hh, a_mm, a_ss, b_hh, b_mm, b_ss;
  logic a_sh, a_sm, a_dt, a_pm, b_sh, b_sm, b_dt, b_pm;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  clock_time_counter u_a (
    .clk(clk), .clr(clr), ._1s(tick_1s), .mode(mode), .inc(inc),
    .hh(a_hh), .mm(a_mm), .ss(a_ss), .set_hh(a_sh), .set_mm(a_sm),
    .day_tick(a_dt), .pm(a_pm)
  );

  clock_time_counter #(.INIT_HH(8'h23), .INIT_MM(8'h59), .INIT_SS(8'h58)) u_b (
    .clk(clk), .clr(clr), ._1s(tick_1s), .mode(mode), .inc(inc),
    .hh(b_hh), .mm(b_mm), .ss(b_ss), .set_hh(b_sh), .set_mm(b_sm),
    .day_tick(b_dt), .pm(b_pm)
  );

  // Reference: time as seconds since midnight, edit mode as 0=run 1=hours 2=minutes.
  int mt[2];
  int mst[2];
  bit mdt[2];
  int minit[2] = '{0, 23*3600 + 59*60 + 58};

  function automatic logic [7:0] bcd(input int n);
    return 8'((n / 10) * 16 + n % 10);
  endfunction

  function automatic logic [7:0] disp_h(input int h);
`ifdef TWELVE_HOUR_EN
    return bcd((h % 12 == 0) ? 12 : h % 12);
`else
    return bcd(h);
`endif
  endfunction

  function automatic logic disp_pm(input int h);
`ifdef TWELVE_HOUR_EN
    return h >= 12;
`else
    return (h < 0);
`endif
  endfunction

  task automatic model_step(input int k, input logic t, input logic m, input logic i, input logic c);
    int h, mi;
    if (c) begin
      mt[k] = minit[k]; mst[k] = 0; mdt[k] = 0;
      return;
    end
    mdt[k] = 0;
    case (mst[k])
      0: begin
        if (t) begin
          mt[k] = (mt[k] + 1) % 86400;
          mdt[k] = (mt[k] == 0);
        end
        if (m) mst[k] = 1;
      end
      1: begin
        if (m) mst[k] = 2;
        else if (i) begin
          h = mt[k] / 3600;
          mt[k] = mt[k] - h * 3600 + ((h + 1) % 24) * 3600;
        end
      end
      default: begin
        if (m) begin
          mst[k] = 0;
          mt[k] = mt[k] - mt[k] % 60;
        end else if (i) begin
          mi = (mt[k] / 60) % 60;
          mt[k] = mt[k] - mi * 60 + ((mi + 1) % 60) * 60;
        end
      end
    endcase
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_dut(input string p, input int k, input logic [7:0] h, input logic [7:0] m,
                         input logic [7:0] s, input logic sh, input logic sm, input logic dt,
                         input logic pmv);
    chk({p, "_hh"}, h, disp_h(mt[k] / 3600));
    chk({p, "_mm"}, m, bcd((mt[k] / 60) % 60));
    chk({p, "_ss"}, s, bcd(mt[k] % 60));
    chk({p, "_set_hh"}, {7'd0, sh}, {7'd0, mst[k] == 1});
    chk({p, "_set_mm"}, {7'd0, sm}, {7'd0, mst[k] == 2});
    chk({p, "_day_tick"}, {7'd0, dt}, {7'd0, mdt[k]});
    chk({p, "_pm"}, {7'd0, pmv}, {7'd0, disp_pm(mt[k] / 3600)});
  endtask

  task automatic cyc(input logic t, input logic m, input logic i, input logic c);
    tick_1s = t; mode = m; inc = i; clr = c;
    @(posedge clk);
    model_step(0, t, m, i, c);
    model_step(1, t, m, i, c);
    #1;
    chk_dut("a", 0, a_hh, a_mm, a_ss, a_sh, a_sm, a_dt, a_pm);
    chk_dut("b", 1, b_hh, b_mm, b_ss, b_sh, b_sm, b_dt, b_pm);
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic incs(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  typedef struct {
    logic t, m, i, c;
    int   eh, em, es;
    logic esh, esm, edt;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int digit_bad;
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2, 0, 1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2, 0, 1, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 1, 1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 1, 0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 1, 0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 1, 1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 2, 1, 2, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0};

    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_a_hh", a_hh, disp_h(0));
    chk("reset_b_ss", b_ss, 8'h58);
    chk("reset_b_mm", b_mm, 8'h59);

    foreach (vecs[n]) begin
      cyc(vecs[n].t, vecs[n].m, vecs[n].i, vecs[n].c);
      chk($sformatf("vec%0d_hh", n), a_hh, disp_h(vecs[n].eh));
      chk($sformatf("vec%0d_mm", n), a_mm, bcd(vecs[n].em));
      chk($sformatf("vec%0d_ss", n), a_ss, bcd(vecs[n].es));
      chk($sformatf("vec%0d_st", n), {6'd0, a_sh, a_sm}, {6'd0, vecs[n].esh, vecs[n].esm});
      chk($sformatf("vec%0d_dt", n), {7'd0, a_dt}, {7'd0, vecs[n].edt});
    end

    // 61 seconds from reset; instance b crosses midnight on the second tick.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    ticks(1);
    chk("b_235959_ss", b_ss, 8'h59);
    chk("b_235959_dt", {7'd0, b_dt}, 8'h00);
    ticks(1);
    chk("b_rollover_hh", b_hh, disp_h(0));
    chk("b_rollover_mm", b_mm, 8'h00);
    chk("b_rollover_ss", b_ss, 8'h00);
    chk("b_rollover_dt", {7'd0, b_dt}, 8'h01);
    ticks(1);
    chk("b_after_dt", {7'd0, b_dt}, 8'h00);
    ticks(58);
    chk("a_61s_hh", a_hh, disp_h(0));
    chk("a_61s_mm", a_mm, 8'h01);
    chk("a_61s_ss", a_ss, 8'h01);

    // Set flow: reach 10:20:35, then edit hours and minutes.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0); incs(10);
    cyc(1'b0, 1'b1, 1'b0, 1'b0); incs(20);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(35);
    chk("setup_hh", a_hh, disp_h(10));
    chk("setup_mm", a_mm, 8'h20);
    chk("setup_ss", a_ss, 8'h35);
    cyc(1'b0, 1'b1, 1'b0, 1'b0); incs(14);
    ticks(3);
    chk("seth_hh", a_hh, disp_h(0));
    chk("seth_flag", {7'd0, a_sh}, 8'h01);
    chk("seth_ss_frozen", a_ss, 8'h35);
    cyc(1'b0, 1'b1, 1'b0, 1'b0); incs(45);
    chk("setm_mm", a_mm, 8'h05);
    chk("setm_hh", a_hh, disp_h(0));
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("exit_ss", a_ss, 8'h00);
    chk("exit_flags", {6'd0, a_sh, a_sm}, 8'h00);

    // BCD carry through 00:09:59 with digit legality watched every cycle.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    digit_bad = 0;
    for (int n = 0; n < 600; n++) begin
      ticks(1);
      if (a_mm[3:0] > 4'd9 || a_mm[7:4] > 4'd5 || a_ss[3:0] > 4'd9 || a_ss[7:4] > 4'd5 ||
          b_mm[3:0] > 4'd9 || b_ss[3:0] > 4'd9 || b_hh[3:0] > 4'd9)
        digit_bad++;
      if (n == 598) chk("bcd_0959_ss", a_ss, 8'h59);
    end
    chk("bcd_1000_mm", a_mm, 8'h10);
    chk("bcd_1000_ss", a_ss, 8'h00);
    chk("bcd_digits", 8'(digit_bad), 8'h00);

    // Collisions.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    ticks(59);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("tick_mode_mm", a_mm, 8'h01);
    chk("tick_mode_ss", a_ss, 8'h00);
    chk("tick_mode_set", {7'd0, a_sh}, 8'h01);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("mode_inc_hh", a_hh, disp_h(0));
    chk("mode_inc_setmm", {7'd0, a_sm}, 8'h01);
    incs(3);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("clr_edit_mm", a_mm, 8'h00);
    chk("clr_edit_flags", {6'd0, a_sh, a_sm}, 8'h00);
    chk("clr_edit_b_ss", b_ss, 8'h58);

    // Random pulses against the model.
    for (int n = 0; n < 4000; n++)
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 499) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_time_counter.md
# clock_time_counter

Time-of-day counter for the digital clock. Consumes the one-cycle 1 Hz tick from the one-second tick generator and keeps hours, minutes and seconds in packed BCD. A three-state set FSM lets the user edit hours and minutes with two debounced button pulses. Outputs feed the seven-segment display driver.

## Interface
Parameters:
- INIT_HH, 8'h00, BCD hour loaded on reset (00..23)
- INIT_MM, 8'h00, BCD minute loaded on reset (00..59)
- INIT_SS, 8'h00, BCD second loaded on reset (00..59)

Ports:
- clk  in  1  system clock (100 MHz)
- clr  in  1  reset; synchronous, active-high
- _1s  in  1  one-cycle tick, once per second
- mode  in  1  one-cycle pulse, advances the set FSM
- inc  in  1  one-cycle pulse, increments the field being edited
- hh  out  8  BCD hours {tens[7:4], units[3:0]}
- mm  out  8  BCD minutes
- ss  out  8  BCD seconds
- set_hh  out  1  high in SET_HH (display blinks hours)
- set_mm  out  1  high in SET_MM
- day_tick  out  1  one-cycle pulse on 23:59:59 -> 00:00:00 rollover
- pm  out  1  PM flag in 12-hour build; constant 0 otherwise

## Operation
- FSM states: RUN, SET_HH, SET_MM. Transitions on mode pulse only: RUN->SET_HH->SET_MM->RUN.
- RUN, _1s high: ss+1. At ss=59: ss->00 and mm+1. At mm=59 as well: mm->00 and hh+1. At hh=23 as well: hh->00 and day_tick fires.
- BCD rules: units 9->0 with tens+1. Seconds/minutes wrap 59->00. Hours wrap 23->00. Digit codes A-F never appear.
- SET_HH: _1s ignored, time frozen. inc: hh+1, 23->00, no carry, no day_tick.
- SET_MM: _1s ignored. inc: mm+1, 59->00, no carry into hh.
- Leaving SET_MM for RUN: ss cleared to 00 on the same edge.
- inc in RUN is ignored.
- mode and inc in the same cycle: mode wins and inc is dropped.
- _1s and mode in the same cycle in RUN: the tick is applied, including any carries or day_tick, and the state moves to SET_HH on the same edge.
- _1s and inc in the same cycle in a SET state: inc applied, tick dropped.
- clr high: hh/mm/ss <= INIT_HH/INIT_MM/INIT_SS, state RUN, day_tick 0. clr overrides all inputs, including mid-edit.

## Timing
- All state is registered on posedge clk. hh/mm/ss/set_hh/set_mm/day_tick come from flops.
- Latency: an input pulse sampled at edge N is visible on the outputs after edge N, one cycle.
- day_tick is high for exactly the one cycle in which outputs first read 00:00:00.
- Reset values: hh=INIT_HH, mm=INIT_MM, ss=INIT_SS, set_hh=0, set_mm=0, day_tick=0, pm=0 (12-hour build: pm follows the INIT_HH mapping).
- Back-to-back pulses on consecutive cycles are each processed.
- Pulses held high longer than one cycle count once per cycle; upstream debouncing guarantees single-cycle pulses.

## Configuration
- Macro: TWELVE_HOUR_EN.
- Defined:
  - The internal hour counter stays 24-hour.
  - hh and pm are mapped combinationally from the registered hour: 00->12 pm=0; 01..11->same pm=0; 12->12 pm=1; 13..23->01..11 pm=1.
  - Set-mode inc still steps the internal 24-hour value, so displayed 11 PM steps to 12 AM.
  - day_tick is unchanged.
- Not defined: hh is the raw 24-hour BCD value and pm is tied to 0.

## Test plan
- Reset with defaults, then 61 `_1s` pulses -> hh=00, mm=01, ss=01, day_tick never high.
- Rollover: INIT=23:59:58, two ticks -> 23:59:59, then 00:00:00 with day_tick high for exactly one cycle.
- BCD carry: from 00:09:59 one tick -> 00:10:00; check no digit ever reads 4'hA.
- Set flow:
  - From 10:20:35 in RUN: mode, then 14 inc -> hh=00, set_hh=1, ticks ignored.
  - Then mode, then 45 inc -> mm=05, hh unchanged.
  - Then mode -> RUN, ss=00.
- Collisions:
  - mode+_1s in RUN at 00:00:59 -> 00:01:00 and set_hh=1.
  - mode+inc in SET_HH -> state SET_MM, hh unchanged.
  - clr during SET_MM -> RUN with the INIT values.
- TWELVE_HOUR_EN build:
  - Internal 00 -> hh=12, pm=0.
  - Internal 13 -> hh=01, pm=1.
  - 11:59:59 plus one tick -> hh=12, pm=1.
